rename_freelist: RTL
====================

Name: rename_freelist

Overview:
- Single-lane register rename stage between decode and dispatch. Architectural sources are mapped to physical registers; each destination gets a new physical register.
- Replaces the counter allocator with a circular free-list FIFO, so physical registers can be freed in any order at retire.
- Retirement clears speculative mappings whose value has been committed to the ARF. Squash restores a clean state in one cycle.

Parameters:
- ARF_SIZE, 32, number of architectural registers; AREG_BITS = $clog2(ARF_SIZE)
- PRF_SIZE, 64, number of physical registers, power of two; PREG_BITS = $clog2(PRF_SIZE)
- ID_BITS, 8, width of the instruction sequence id

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  rename accepts instruction this cycle
- in_id  in  ID_BITS  instruction sequence id
- in_rd_valid  in  1  instruction writes a destination
- in_rd  in  AREG_BITS  destination areg
- in_rs1, in_rs2  in  AREG_BITS  source aregs
- out_valid  out  1  renamed instruction valid
- out_ready  in  1  dispatch ready
- out_id  out  ID_BITS  copy of in_id
- out_rd_valid  out  1  copy of in_rd_valid
- out_prd  out  PREG_BITS  allocated preg; only meaningful when out_rd_valid=1
- out_prs1, out_prs2  out  PREG_BITS  mapped source pregs
- out_prs1_renamed, out_prs2_renamed  out  1  1 = operand comes from the PRF, 0 = operand comes from the ARF
- retire_valid  in  1  a destination-writing instruction retires
- retire_ard  in  AREG_BITS  retiring areg
- retire_prd  in  PREG_BITS  retiring preg, returned to the free list
- squash_valid  in  1  flush all speculative state
- free_count  out  PREG_BITS+1  number of entries in the free list

Behaviour:
- State:
  - Map table: map[ARF_SIZE] of PREG_BITS, plus map_valid[ARF_SIZE].
  - Free-list FIFO: fl[PRF_SIZE] of PREG_BITS, head and tail of PREG_BITS, count of PREG_BITS+1.
- Reset (rstn=0 at posedge):
  - map_valid = 0; fl[i] = i; head = 0; tail = 0; count = PRF_SIZE.
  - Outputs after reset: free_count = PRF_SIZE; out_valid = in_valid (pass-through); in_ready = out_ready.
- Stall and handshake (combinational, zero latency):
  - stall = in_valid & in_rd_valid & (count==0)
  - in_ready = out_ready & ~stall & ~squash_valid
  - out_valid = in_valid & ~stall & ~squash_valid
  - fire = in_valid & in_ready
  - alloc = fire & in_rd_valid
- Rename outputs:
  - out_prd = fl[head].
  - out_prsN = map[in_rsN]; out_prsN_renamed = map_valid[in_rsN].
  - All are driven combinationally from the current state, regardless of fire.
  - A source equal to in_rd sees the old mapping; the new mapping is visible from the next cycle.
- On alloc at posedge:
  - map[in_rd] <= fl[head]; map_valid[in_rd] <= 1; head <= head+1 (wraps mod PRF_SIZE).
- On retire_valid at posedge:
  - fl[tail] <= retire_prd; tail <= tail+1 (wraps).
  - If map_valid[retire_ard] & map[retire_ard]==retire_prd, then map_valid[retire_ard] <= 0 (value now in ARF).
  - No broadcast search; preg uniqueness guarantees the match is exact.
- Simultaneous events:
  - alloc and retire in the same cycle: count unchanged.
  - alloc and retire clear on the same areg: the alloc write wins (map_valid stays 1 with the new preg).
  - count==0 with retire_valid in the same cycle: still stalls; there is no same-cycle free-to-alloc bypass.
- count arithmetic: count <= count + retire_valid - alloc.
- Squash (priority over alloc and retire in the same cycle):
  - map_valid <= 0; head <= tail; count <= PRF_SIZE.
  - The free list keeps its contents, reinterpreted as full. Every preg is free because the ARF holds all committed state.
  - A retire arriving in the squash cycle is dropped; the retire unit guarantees this never happens.
- Error assertions (simulation only):
  - retire_valid while count==PRF_SIZE (overflow).
  - retire_prd already present in the free list (double free).

Optional Feature:
- Macro RENAME_ZERO_AREG_EN.
- Defined:
  - areg 0 is hardwired. in_rd_valid with in_rd==0 does not allocate, does not stall and does not update the map; out_rd_valid is forced to 0.
  - in_rsN==0 always gives out_prsN_renamed = 0.
- Undefined: areg 0 is treated like any other areg.

Test Plan:
- Reset, then rename rd=5 with rs1=5 -> out_prd=0 and out_prs1_renamed=0. Next instruction with rs1=5 -> out_prs1=0, out_prs1_renamed=1; free_count goes 64 to 63.
- 64 back-to-back allocs without retire -> prd sequence 0..63, free_count=0. The 65th instruction with rd -> in_ready=0, out_valid=0. A no-rd instruction still passes.
- With free_count=0, retire prd=7 -> stalled instruction fires the next cycle with out_prd=7, and head wraps to 0.
- Map areg 3 to preg 10, then retire ard=3 prd=10 -> next read of rs=3 gives renamed=0. Retire ard=3 prd=10 in the same cycle as an alloc of rd=3 -> map stays valid with the new preg.
- Several mappings live, squash_valid plus in_valid -> no fire that cycle. Next cycle all reads renamed=0, free_count=64, and allocation resumes from the old tail position.
- With RENAME_ZERO_AREG_EN: instruction with rd=0 at free_count=0 -> fires without stall; out_rd_valid=0; free_count unchanged.

Source files
------------

// File: rtl/rename_freelist.sv
// Rename stage with a circular free-list allocator; optional hardwired areg 0 via RENAME_ZERO_AREG_EN.
// Latency: zero, since all rename outputs are combinational from the current map and free list.
// Backpressure: in_ready follows out_ready; it drops when a destination finds the free list empty or on squash.
module rename_freelist #(
   parameter int ARF_SIZE = 32,
   parameter int PRF_SIZE = 64,
   parameter int ID_BITS  = 8,
   localparam int AREG_BITS = $clog2(ARF_SIZE),
   localparam int PREG_BITS = $clog2(PRF_SIZE)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ID_BITS-1:0]   in_id,
   input  logic                 in_rd_valid,
   input  logic [AREG_BITS-1:0] in_rd,
   input  logic [AREG_BITS-1:0] in_rs1,
   input  logic [AREG_BITS-1:0] in_rs2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ID_BITS-1:0]   out_id,
   output logic                 out_rd_valid,
   output logic [PREG_BITS-1:0] out_prd,
   output logic [PREG_BITS-1:0] out_prs1,
   output logic [PREG_BITS-1:0] out_prs2,
   output logic                 out_prs1_renamed,
   output logic                 out_prs2_renamed,
   input  logic                 retire_valid,
   input  logic [AREG_BITS-1:0] retire_ard,
   input  logic [PREG_BITS-1:0] retire_prd,
   input  logic                 squash_valid,
   output logic [PREG_BITS:0]   free_count
);

   localparam logic [PREG_BITS:0] FULL = (PREG_BITS+1)'(PRF_SIZE);

   logic [PREG_BITS-1:0] map       [ARF_SIZE];
   logic [ARF_SIZE-1:0]  map_valid;
   logic [PREG_BITS-1:0] fl        [PRF_SIZE];
   logic [PREG_BITS-1:0] head;
   logic [PREG_BITS-1:0] tail;
   logic [PREG_BITS:0]   count;

   logic rd_eff;
   logic rs1_ok;
   logic rs2_ok;
   logic stall;
   logic fire;
   logic alloc;

`ifdef RENAME_ZERO_AREG_EN
   // Areg 0 never owns a physical register and always reads from the ARF.
   assign rd_eff = in_rd_valid & (in_rd != '0);
   assign rs1_ok = (in_rs1 != '0);
   assign rs2_ok = (in_rs2 != '0);
`else
   assign rd_eff = in_rd_valid;
   assign rs1_ok = 1'b1;
   assign rs2_ok = 1'b1;
`endif

   assign stall     = in_valid & rd_eff & (count == '0);
   assign in_ready  = out_ready & ~stall & ~squash_valid;
   assign out_valid = in_valid & ~stall & ~squash_valid;
   assign fire      = in_valid & in_ready;
   assign alloc     = fire & rd_eff;

   assign out_id           = in_id;
   assign out_rd_valid     = rd_eff;
   assign out_prd          = fl[head];
   assign out_prs1         = map[in_rs1];
   assign out_prs2         = map[in_rs2];
   assign out_prs1_renamed = map_valid[in_rs1] & rs1_ok;
   assign out_prs2_renamed = map_valid[in_rs2] & rs2_ok;
   assign free_count       = count;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         map_valid <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= FULL;
         for (int i = 0; i < PRF_SIZE; i++) begin
            fl[i] <= PREG_BITS'(i);
         end
      end else if (squash_valid) begin
         // Everything committed lives in the ARF, so the whole ring becomes free as-is.
         map_valid <= '0;
         head      <= tail;
         count     <= FULL;
      end else begin
         if (retire_valid) begin
            fl[tail] <= retire_prd;
            tail     <= tail + 1'b1;
            if (map_valid[retire_ard] && (map[retire_ard] == retire_prd)) begin
               map_valid[retire_ard] <= 1'b0;
            end
         end
         // Placed after the retire clear so a same-areg allocation keeps the new mapping.
         if (alloc) begin
            map[in_rd]       <= fl[head];
            map_valid[in_rd] <= 1'b1;
            head             <= head + 1'b1;
         end
         count <= count + {{PREG_BITS{1'b0}}, retire_valid} - {{PREG_BITS{1'b0}}, alloc};
      end
   end

`ifndef SYNTHESIS
   logic dup_free;

   always_comb begin
      dup_free = 1'b0;
      for (int i = 0; i < PRF_SIZE; i++) begin
         if (((PREG_BITS+1)'(i) < count) && (fl[head + PREG_BITS'(i)] == retire_prd)) begin
            dup_free = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && retire_valid && !squash_valid) begin
         assert (count != FULL);
         assert (!dup_free);
      end
   end
`endif

endmodule
